// File: rtl/vcve2_pkg.sv
// Shared types and helpers for the vector integer add/sub path of the vector-extended cve2 core.
package vcve2_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } vadd_state_e;

    localparam logic [1:0] SEW_ILLEGAL = 2'b11;
    localparam int         LANE_BITS   = 8;

    // Elements packed into one 32-bit word for a given element width.
    function automatic logic [2:0] epw_f(sew_e sew);
        case (sew)
            SEW8:    epw_f = 3'd4;
            SEW16:   epw_f = 3'd2;
            default: epw_f = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/vcve2_fracturable_adder.sv
// Byte-sliced adder whose carry chain breaks at element boundaries; bit 0 of the operands
// carries the word-level carry-in, lane starts above byte 0 inject is_sub directly.
module vcve2_fracturable_adder
    import vcve2_pkg::*;
#(
    parameter int PIPE_WIDTH = 32
) (
    input  logic [PIPE_WIDTH:0]   i_op_a,
    input  logic [PIPE_WIDTH:0]   i_op_b,
    input  sew_e                  i_sew,
    input  logic                  i_is_sub,
    output logic [PIPE_WIDTH+1:0] o_result
);

    localparam int NUM_LANES = PIPE_WIDTH / LANE_BITS;

    function automatic logic lane_start_f(sew_e sew, int lane);
        case (sew)
            SEW8:    lane_start_f = (lane != 0);
            SEW16:   lane_start_f = (lane != 0) && ((lane % 2) == 0);
            default: lane_start_f = (lane != 0) && ((lane % 4) == 0);
        endcase
    endfunction

    always_comb begin
        logic [NUM_LANES:0] carry;
        logic [8:0]         lane_sum;
        logic               cin;
        carry       = '0;
        lane_sum    = '0;
        cin         = 1'b0;
        o_result    = '0;
        o_result[0] = i_op_a[0] ^ i_op_b[0];
        carry[0]    = i_op_a[0] & i_op_b[0];
        for (int k = 0; k < NUM_LANES; k++) begin
            cin = lane_start_f(i_sew, k) ? i_is_sub : carry[k];
            lane_sum = {1'b0, i_op_a[LANE_BITS*k+1 +: LANE_BITS]}
                     + {1'b0, i_op_b[LANE_BITS*k+1 +: LANE_BITS]}
                     + {8'b0, cin};
            o_result[LANE_BITS*k+1 +: LANE_BITS] = lane_sum[7:0];
            carry[k+1] = lane_sum[8];
        end
        o_result[PIPE_WIDTH+1] = carry[NUM_LANES];
    end

endmodule

// File: rtl/vcve2_vadd_sequencer.sv
// vadd.vv / vsub.vv sequencer: accepts a command, streams packed source word pairs through
// the fracturable adder and returns packed results on a registered valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting source beats until every element has been issued
// DRAIN | last result beat waiting in the output register
// DONE  | one-cycle completion pulse
module vcve2_vadd_sequencer
    import vcve2_pkg::*;
#(
    parameter int VL_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [VL_WIDTH-1:0] vl_i,
    input  logic [1:0]          sew_i,
    input  logic                is_sub_i,
    input  logic                kill_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_a_i,
    input  logic [31:0]         in_b_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_data_o,
    output logic [3:0]          out_be_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    vadd_state_e         r_state;
    vadd_state_e         w_state_next;
    sew_e                r_sew;
    logic                r_is_sub;
    logic [VL_WIDTH-1:0] r_rem;
    logic                r_out_valid;
    logic [31:0]         r_out_data;
    logic [3:0]          r_out_be;
    logic                r_err;

    logic                w_in_ready;
    logic                w_busy;
    logic                w_done;
    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_start_ok;
    logic [VL_WIDTH-1:0] w_epw;
    logic [VL_WIDTH-1:0] w_take;
    logic [VL_WIDTH-1:0] w_rem_next;
    logic                w_tail;
    logic [3:0]          w_be;
    logic [32:0]         w_op_a;
    logic [32:0]         w_op_b;
    logic [33:0]         w_sum;
    logic                w_unused_sum_bits;

    // Tail beat: only the low r elements of the word are active.
    function automatic logic [3:0] tail_be_f(sew_e sew, logic [1:0] r);
        case (sew)
            SEW8:    tail_be_f = (4'b0001 << r) - 4'b0001;
            SEW16:   tail_be_f = 4'b0011;
            default: tail_be_f = 4'b1111;
        endcase
    endfunction

    assign w_epw      = VL_WIDTH'(epw_f(r_sew));
    assign w_tail     = (r_rem < w_epw);
    assign w_take     = w_tail ? r_rem : w_epw;
    assign w_rem_next = r_rem - w_take;
    assign w_be       = w_tail ? tail_be_f(r_sew, r_rem[1:0]) : 4'b1111;

    assign w_in_hs    = in_valid_i & w_in_ready;
    assign w_out_hs   = r_out_valid & out_ready_i;
    assign w_start_ok = start_i & (r_state == IDLE) & ~kill_i & (sew_i != SEW_ILLEGAL);

    assign w_op_a = {in_a_i, 1'b1};
    assign w_op_b = r_is_sub ? {~in_b_i, 1'b1} : {in_b_i, 1'b0};

    vcve2_fracturable_adder #(
        .PIPE_WIDTH (32)
    ) u_adder (
        .i_op_a   (w_op_a),
        .i_op_b   (w_op_b),
        .i_sew    (r_sew),
        .i_is_sub (r_is_sub),
        .o_result (w_sum)
    );

    assign w_unused_sum_bits = w_sum[33] ^ w_sum[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i && (sew_i != SEW_ILLEGAL)) begin
                    w_state_next = (vl_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_in_hs && (w_rem_next == '0)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_hs) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (kill_i) begin
            w_state_next = IDLE;
        end
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = (r_state != IDLE);
        w_done     = (r_state == DONE);
        if (r_state == RUN) begin
            w_in_ready = ~r_out_valid | out_ready_i;
        end
    end

    // Output register reloads on every accepted beat, which also covers a simultaneous drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sew       <= SEW8;
            r_is_sub    <= 1'b0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_be    <= '0;
            r_err       <= 1'b0;
        end else if (kill_i) begin
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= start_i & (r_state == IDLE) & (sew_i == SEW_ILLEGAL);
            if (w_start_ok) begin
                r_sew    <= sew_e'(sew_i);
                r_is_sub <= is_sub_i;
                r_rem    <= vl_i;
            end else if (w_in_hs) begin
                r_rem <= w_rem_next;
            end
            if (w_in_hs) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sum[32:1];
                r_out_be    <= w_be;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_be_o    = r_out_be;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_vcve2_vadd_sequencer.sv
// Self-checking bench for vcve2_vadd_sequencer: element-level reference model plus directed cases.
module tb_vcve2_vadd_sequencer;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  vl_i;
    logic [1:0]  sew_i;
    logic        is_sub_i;
    logic        kill_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_a_i;
    logic [31:0] in_b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_be_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    vcve2_vadd_sequencer #(.VL_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .vl_i        (vl_i),
        .sew_i       (sew_i),
        .is_sub_i    (is_sub_i),
        .kill_i      (kill_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_be_o    (out_be_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    int          m_sew;
    bit          m_sub;
    int          m_rem;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    logic        stall_prev = 1'b0;
    logic [35:0] stall_val;

    logic [31:0] ta[4];
    logic [31:0] tb_[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Each element is an independent sew-wide add/sub, modulo the element width.
    function automatic logic [31:0] lane_op(logic [31:0] a, logic [31:0] b, int sew, bit sub);
        int          w;
        logic [31:0] res;
        w   = 8 << sew;
        res = '0;
        for (int i = 0; i < 32 / w; i++) begin
            longint mask, x, y, r;
            mask = (longint'(1) << w) - 1;
            x = longint'(a >> (i * w)) & mask;
            y = longint'(b >> (i * w)) & mask;
            r = sub ? (x - y) : (x + y);
            res = res | 32'((r & mask) << (i * w));
        end
        return res;
    endfunction

    function automatic logic [3:0] exp_be(int sew, int rem);
        int epw, n;
        epw = 4 >> sew;
        n   = (rem < epw) ? rem : epw;
        return 4'((1 << (n * (1 << sew))) - 1);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rst_i || kill_i) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 64'(out_valid_o), 64'd1);
                    chk("hold_data_be", 64'({out_be_o, out_data_o}), 64'(stall_val));
                end
                if (out_valid_o && !out_ready_i) begin
                    chk("in_ready_under_stall", 64'(in_ready_o), 64'd0);
                    stall_prev = 1'b1;
                    stall_val  = {out_be_o, out_data_o};
                end else begin
                    stall_prev = 1'b0;
                end
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 64'(out_data_o), 64'hDEAD_0000_0000);
                    else chk("beat_data_be", 64'({out_be_o, out_data_o}), 64'(exp_q.pop_front()));
                    got_q.push_back({out_be_o, out_data_o});
                end
                if (in_valid_i && in_ready_o) begin
                    exp_q.push_back({exp_be(m_sew, m_rem), lane_op(in_a_i, in_b_i, m_sew, m_sub)});
                    m_rem = m_rem - (((4 >> m_sew) < m_rem) ? (4 >> m_sew) : m_rem);
                end
                if (done_o) done_cnt++;
                if (err_o) err_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int vl, input int sew, input bit sub);
        start_i  = 1'b1;
        vl_i     = 8'(vl);
        sew_i    = 2'(sew);
        is_sub_i = sub;
        if (sew != 3) begin
            m_sew = sew;
            m_sub = sub;
            m_rem = vl;
        end
        tick();
        start_i = 1'b0;
    endtask

    task automatic feed(input int nb);
        for (int i = 0; i < nb; i++) begin
            int g;
            in_valid_i = 1'b1;
            in_a_i     = ta[i];
            in_b_i     = tb_[i];
            g = 0;
            @(negedge clk);
            while (!in_ready_o && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready_o) chk("in_ready_timeout", 64'(in_ready_o), 64'd1);
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (!done_o && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(name, 64'(done_o), 64'd1);
        @(negedge clk);
        chk("done_single_cycle", 64'(done_o), 64'd0);
    endtask

    initial begin
        int d0;
        rst_i = 1'b1; start_i = 1'b0; vl_i = '0; sew_i = '0; is_sub_i = 1'b0;
        kill_i = 1'b0; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data", 64'(out_data_o), 64'd0);
        chk("rst_out_be", 64'(out_be_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd0);

        // sew8 add, one full beat, byte lanes isolated
        got_q.delete();
        do_start(4, 0, 0);
        ta[0] = 32'h01FF7F80; tb_[0] = 32'h01010101;
        feed(1);
        @(negedge clk);
        chk("t1_drain_in_ready", 64'(in_ready_o), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done_o), 64'd1);
        @(negedge clk);
        chk("t1_done_once", 64'(done_o), 64'd0);
        chk("t1_busy_clear", 64'(busy_o), 64'd0);
        chk("t1_beats", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("t1_lit", 64'(got_q[0]), 64'h0F_0200_8081);

        // sub/add across widths
        got_q.delete();
        do_start(2, 1, 1);
        ta[0] = 32'h00000005; tb_[0] = 32'h00010006;
        feed(1);
        wait_done("t2a_done");
        do_start(1, 2, 1);
        ta[0] = 32'h00000000; tb_[0] = 32'h00000001;
        feed(1);
        wait_done("t2b_done");
        do_start(1, 2, 0);
        ta[0] = 32'hFFFFFFFF; tb_[0] = 32'h00000001;
        feed(1);
        wait_done("t2c_done");
        chk("t2_beats", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("t2a_lit", 64'(got_q[0]), 64'h0F_FFFF_FFFF);
            chk("t2b_lit", 64'(got_q[1]), 64'h0F_FFFF_FFFF);
            chk("t2c_lit", 64'(got_q[2]), 64'h0F_0000_0000);
        end

        // sew8 vl=5 with a tail beat; start_i held while busy must be ignored
        got_q.delete();
        d0 = err_cnt;
        do_start(5, 0, 0);
        ta[0] = 32'h04030201; tb_[0] = 32'h10101010;
        ta[1] = 32'h04030201; tb_[1] = 32'h10101010;
        start_i = 1'b1; vl_i = 8'd9; sew_i = 2'b10; is_sub_i = 1'b1;
        feed(2);
        start_i = 1'b0;
        @(negedge clk);
        chk("t3_drain_in_ready", 64'(in_ready_o), 64'd0);
        chk("t3_drain_busy", 64'(busy_o), 64'd1);
        wait_done("t3_done");
        chk("t3_beats", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("t3_beat0", 64'(got_q[0]), 64'h0F_1413_1211);
            chk("t3_beat1", 64'(got_q[1]), 64'h01_1413_1211);
        end
        chk("t3_no_err", 64'(err_cnt), 64'(d0));

        // backpressure mid-stream
        got_q.delete();
        do_start(12, 0, 0);
        ta[0] = 32'h01020304; tb_[0] = 32'h01010101;
        ta[1] = 32'h05060708; tb_[1] = 32'h01010101;
        ta[2] = 32'h090A0B0C; tb_[2] = 32'h01010101;
        fork
            feed(3);
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!out_valid_o && g < 40) begin
                    @(negedge clk);
                    g++;
                end
                tick();
                out_ready_i = 1'b0;
                repeat (3) tick();
                out_ready_i = 1'b1;
                @(negedge clk);
                chk("t4_resume_in_ready", 64'(in_ready_o), 64'd1);
                chk("t4_resume_out_valid", 64'(out_valid_o), 64'd1);
            end
        join
        wait_done("t4_done");
        chk("t4_beats", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("t4_beat0", 64'(got_q[0]), 64'h0F_0203_0405);
            chk("t4_beat1", 64'(got_q[1]), 64'h0F_0607_0809);
            chk("t4_beat2", 64'(got_q[2]), 64'h0F_0A0B_0C0D);
        end
        chk("model_drained", 64'(exp_q.size()), 64'd0);

        // vl=0 and illegal sew
        got_q.delete();
        do_start(0, 0, 0);
        @(negedge clk);
        chk("t5_vl0_done", 64'(done_o), 64'd1);
        @(negedge clk);
        chk("t5_vl0_done_once", 64'(done_o), 64'd0);
        chk("t5_vl0_idle", 64'(busy_o), 64'd0);
        chk("t5_vl0_no_beats", 64'(got_q.size()), 64'd0);
        do_start(5, 3, 0);
        @(negedge clk);
        chk("t5_err_pulse", 64'(err_o), 64'd1);
        chk("t5_err_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("t5_err_once", 64'(err_o), 64'd0);
        chk("t5_err_still_idle", 64'(busy_o), 64'd0);

        // kill after first of three beats, together with a start that must be dropped
        do_start(12, 0, 0);
        ta[0] = 32'h11111111; tb_[0] = 32'h22222222;
        feed(1);
        kill_i = 1'b1; start_i = 1'b1; vl_i = 8'd3; sew_i = 2'b00;
        tick();
        kill_i = 1'b0; start_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_kill_out_valid", 64'(out_valid_o), 64'd0);
        chk("t6_kill_busy", 64'(busy_o), 64'd0);
        chk("t6_kill_in_ready", 64'(in_ready_o), 64'd0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        chk("t6_kill_no_done", 64'(done_cnt), 64'(d0));
        chk("t6_start_dropped", 64'(busy_o), 64'd0);
        got_q.delete();
        do_start(3, 1, 1);
        ta[0] = 32'h00050009; tb_[0] = 32'h00020003;
        ta[1] = 32'h12340001; tb_[1] = 32'h00000002;
        feed(2);
        wait_done("t6_restart_done");
        chk("t6_beats", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("t6_beat0", 64'(got_q[0]), 64'h0F_0003_0006);
            chk("t6_beat1", 64'(got_q[1]), 64'h03_1234_FFFF);
        end

        // reset mid-RUN with a held result
        do_start(8, 0, 0);
        out_ready_i = 1'b0;
        ta[0] = 32'hA5A5A5A5; tb_[0] = 32'h01020304;
        feed(1);
        @(negedge clk);
        chk("t7_held_valid", 64'(out_valid_o), 64'd1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t7_rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("t7_rst_out_data", 64'(out_data_o), 64'd0);
        chk("t7_rst_out_be", 64'(out_be_o), 64'd0);
        chk("t7_rst_busy", 64'(busy_o), 64'd0);
        chk("t7_rst_done", 64'(done_o), 64'd0);
        chk("t7_rst_in_ready", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
